// File: rtl/rdb_resp_egress.sv
`default_nettype none
// ============================================================================
// Module  : rdb_resp_egress
// Brief   : Captures RDB read lines into a credit-protected FIFO and streams
//           them beat by beat to the upstream port with per-line completion.
// Revision: 1.0  initial release
// ============================================================================
module rdb_resp_egress #(
    parameter int DEPTH        = 4,
    parameter int BEATS        = 2,
    parameter int DATA_WIDTH   = 256,
    parameter int TXNID_WIDTH  = 8,
    parameter int ROB_ID_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rd_issue,
    output logic                          credit_ok,
    input  logic                          rdb_data_vld,
    input  logic [BEATS*DATA_WIDTH-1:0]   rdb_data,
    input  logic [TXNID_WIDTH-1:0]        rdb_txnid,
    input  logic [ROB_ID_WIDTH-1:0]       rdb_rob_entry_id,
    output logic                          us_resp_vld,
    input  logic                          us_resp_rdy,
    output logic [DATA_WIDTH-1:0]         us_resp_data,
    output logic [TXNID_WIDTH-1:0]        us_resp_txnid,
    output logic [ROB_ID_WIDTH-1:0]       us_resp_rob_id,
    output logic [$clog2(BEATS)-1:0]      us_resp_beat,
    output logic                          us_resp_last,
    output logic                          resp_done,
    output logic [ROB_ID_WIDTH-1:0]       resp_done_idx,
    output logic                          err
);

    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_beat_w = $clog2(BEATS);
    localparam int c_line_w = BEATS * DATA_WIDTH;

    logic [c_line_w-1:0]     r_mem_line  [DEPTH];
    logic [TXNID_WIDTH-1:0]  r_mem_txnid [DEPTH];
    logic [ROB_ID_WIDTH-1:0] r_mem_rob   [DEPTH];

    logic [c_ptr_w-1:0]      r_wr_ptr;
    logic [c_ptr_w-1:0]      r_rd_ptr;
    logic [c_cnt_w-1:0]      r_fifo_cnt;
    logic [c_cnt_w-1:0]      r_inflight_cnt;
    logic [c_beat_w-1:0]     r_beat_cnt;
    logic                    r_done;
    logic [ROB_ID_WIDTH-1:0] r_done_idx;
    logic                    r_err;

    logic [c_cnt_w:0]        w_occupancy;
    logic                    w_full;
    logic                    w_hs;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_err_set;
    logic [c_line_w-1:0]     w_head_line;
    logic [DATA_WIDTH-1:0]   w_beat_data;

    // Credit is derived purely from registered counts so rdy never reaches it.
    assign w_occupancy = {1'b0, r_fifo_cnt} + {1'b0, r_inflight_cnt};
    assign credit_ok   = w_occupancy < (c_cnt_w + 1)'(DEPTH);

    assign w_full  = (r_fifo_cnt == c_cnt_w'(DEPTH));
    assign w_hs    = us_resp_vld & us_resp_rdy;
    assign w_pop   = w_hs & (r_beat_cnt == c_beat_w'(BEATS - 1));
    assign w_push  = rdb_data_vld & (~w_full | w_pop);

    assign w_err_set = (rd_issue & ~credit_ok)
                     | (rdb_data_vld & (r_inflight_cnt == '0))
                     | (rdb_data_vld & w_full & ~w_pop);

    assign w_head_line = r_mem_line[r_rd_ptr];

    always_comb begin
        w_beat_data = '0;
        w_beat_data = w_head_line[int'(r_beat_cnt)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Payloads are gated by valid so the storage itself needs no reset.
    assign us_resp_vld    = (r_fifo_cnt != '0);
    assign us_resp_data   = us_resp_vld ? w_beat_data : '0;
    assign us_resp_txnid  = us_resp_vld ? r_mem_txnid[r_rd_ptr] : '0;
    assign us_resp_rob_id = us_resp_vld ? r_mem_rob[r_rd_ptr] : '0;
    assign us_resp_beat   = r_beat_cnt;
    assign us_resp_last   = (r_beat_cnt == c_beat_w'(BEATS - 1));
    assign resp_done      = r_done;
    assign resp_done_idx  = r_done_idx;
    assign err            = r_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_line[r_wr_ptr]  <= rdb_data;
            r_mem_txnid[r_wr_ptr] <= rdb_txnid;
            r_mem_rob[r_wr_ptr]   <= rdb_rob_entry_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_fifo_cnt     <= '0;
            r_inflight_cnt <= '0;
            r_beat_cnt     <= '0;
            r_done         <= 1'b0;
            r_done_idx     <= '0;
            r_err          <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_fifo_cnt <= r_fifo_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_fifo_cnt <= r_fifo_cnt - 1'b1;
            end

            // Over-issue saturates at DEPTH; a stray line cannot underflow.
            if (rd_issue && !rdb_data_vld) begin
                if (r_inflight_cnt != c_cnt_w'(DEPTH)) begin
                    r_inflight_cnt <= r_inflight_cnt + 1'b1;
                end
            end else if (rdb_data_vld && !rd_issue) begin
                if (r_inflight_cnt != '0) begin
                    r_inflight_cnt <= r_inflight_cnt - 1'b1;
                end
            end

            if (w_hs) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_done_idx <= r_mem_rob[r_rd_ptr];
            end
            r_done <= w_pop;
            r_err  <= r_err | w_err_set;
        end
    end

endmodule
`default_nettype wire
